// File: rtl/rotor_step_sequencer_if.sv
// ----------------------------------------------------------------------------
// rotor_step_sequencer_if
//   Groups the letter input handshake and the result output handshake of the
//   rotor step sequencer.
//   slave  : sequencer view (accepts letters, presents results)
//   master : environment view (supplies letters, consumes results)
//   Signals:
//     in_valid  / in_char  / in_ready   letter input handshake (in_char 0-25)
//     out_valid / out_char / out_err / out_ready   result handshake
// ----------------------------------------------------------------------------
interface rotor_step_sequencer_if;
  logic       in_valid;
  logic [4:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_err;
  logic       out_ready;

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char, out_err
  );

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char, out_err
  );
endinterface

// File: rtl/rotor_step_sequencer.sv
// ----------------------------------------------------------------------------
// rotor_step_sequencer
//   Sequences one letter at a time through an external rotor datapath.
//   On each accepted letter the three rotor positions step odometer-style
//   (with the rotor1 double-step), the datapath is given SETTLE cycles, and
//   its result is held on the output handshake until consumed.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     load, init_pos0..2       latch start positions (reduced mod 26) in IDLE
//     pos0..2                  current rotor positions to the datapath
//     path_char                letter driven into the datapath
//     path_result              datapath output letter
//     bus (slave)              letter input and result output handshakes
// ----------------------------------------------------------------------------
module rotor_step_sequencer #(
  parameter logic [4:0]  NOTCH0 = 5'd16,
  parameter logic [4:0]  NOTCH1 = 5'd4,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] init_pos0,
  input  logic [4:0] init_pos1,
  input  logic [4:0] init_pos2,
  output logic [4:0] pos0,
  output logic [4:0] pos1,
  output logic [4:0] pos2,
  output logic [4:0] path_char,
  input  logic [4:0] path_result,
  rotor_step_sequencer_if.slave bus
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_STEP        = 2'd1,
    S_SETTLE_WAIT = 2'd2,
    S_HOLD        = 2'd3
  } state_t;

  state_t     state_q;
  logic [4:0] pos0_q, pos1_q, pos2_q;
  logic [4:0] path_char_q;
  logic [4:0] out_char_q;
  logic       out_err_q;
  logic       out_valid_q;
  logic [3:0] cnt_q;

  // Reduce a 5-bit value into the 0-25 letter range.
  function automatic logic [4:0] mod26(input logic [4:0] v);
    return (v > 5'd25) ? (v - 5'd26) : v;
  endfunction

  // Advance one rotor position, wrapping 25 back to 0.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : (v + 5'd1);
  endfunction

  // Ready only in IDLE; a load in the same cycle takes priority over a letter,
  // and reset blocks acceptance combinationally.
  assign bus.in_ready  = (state_q == S_IDLE) && !load && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign bus.out_err   = out_err_q;
  assign pos0          = pos0_q;
  assign pos1          = pos1_q;
  assign pos2          = pos2_q;
  assign path_char     = path_char_q;

  // Sequencer FSM with its registered positions, datapath letter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos0_q      <= 5'd0;
      pos1_q      <= 5'd0;
      pos2_q      <= 5'd0;
      path_char_q <= 5'd0;
      out_char_q  <= 5'd0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            pos0_q <= mod26(init_pos0);
            pos1_q <= mod26(init_pos1);
            pos2_q <= mod26(init_pos2);
          end else if (bus.in_valid) begin
            path_char_q <= bus.in_char;
            state_q     <= S_STEP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_STEP: begin
          if (path_char_q > 5'd25) begin
            // Out-of-range letter: echo it back flagged, rotors untouched.
            out_char_q  <= path_char_q;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            // All step decisions use the pre-step positions; a rotor1 sitting
            // on its notch steps itself and rotor2 (the double-step).
            pos0_q <= inc26(pos0_q);
            if ((pos0_q == NOTCH0) || (pos1_q == NOTCH1)) begin
              pos1_q <= inc26(pos1_q);
            end else begin
              pos1_q <= pos1_q;
            end
            if (pos1_q == NOTCH1) begin
              pos2_q <= inc26(pos2_q);
            end else begin
              pos2_q <= pos2_q;
            end
            cnt_q   <= SETTLE_CNT;
            state_q <= S_SETTLE_WAIT;
          end
        end
        S_SETTLE_WAIT: begin
          // The last settle cycle is the one that sees the counter at 1.
          if (cnt_q <= 4'd1) begin
            cnt_q       <= 4'd0;
            out_char_q  <= path_result;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
